dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_dma_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// dma_arbiter
//   Round-robin arbiter that lets NUM_MASTERS DMA masters share one DMA
//   engine. A granted master hands over its command with m_start. The
//   arbiter latches the command, launches the engine with a one-cycle
//   eng_start and waits for eng_done. It then pulses done to that master
//   and moves the round-robin pointer past it.
//
//   Optional feature macro: DMA_ARB_TIMEOUT_EN
//     When it is defined, a grant held for TIMEOUT_CYCLES without m_start
//     is revoked and the sticky timeout_err flag is set.
//
//   Ports
//     clk, rst            clock; asynchronous active-high reset
//     req[N]              per-master request level
//     permit[N]           one-hot grant, high only in GRANT
//     m_src_ID .. m_size  flattened per-master command fields, master i at slice i
//     m_start[N]          per-master command strobe, honoured only from the granted master
//     done[N]             per-master one-cycle completion pulse
//     eng_*               latched command presented to the engine
//     eng_start           one-cycle engine launch
//     eng_done            engine completion, sampled only in BUSY
//     timeout_err         sticky grant-timeout flag (DMA_ARB_TIMEOUT_EN only)
//
//   Field widths come from the shared ID_WIDTH / ADDR_WIDTH / DMA_SIZE_WIDTH
//   macros. The fallbacks below apply only when no shared definition is present.

`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DMA_SIZE_WIDTH
`define DMA_SIZE_WIDTH 16
`endif

module dma_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_MASTERS-1:0]                  req,
  output logic [NUM_MASTERS-1:0]                  permit,
  input  logic [NUM_MASTERS*`ID_WIDTH-1:0]        m_src_ID,
  input  logic [NUM_MASTERS*`ADDR_WIDTH-1:0]      m_src_addr,
  input  logic [NUM_MASTERS*`ID_WIDTH-1:0]        m_dst_ID,
  input  logic [NUM_MASTERS*`ADDR_WIDTH-1:0]      m_dst_addr,
  input  logic [NUM_MASTERS*`DMA_SIZE_WIDTH-1:0]  m_size,
  input  logic [NUM_MASTERS-1:0]                  m_start,
  output logic [NUM_MASTERS-1:0]                  done,
  output logic [`ID_WIDTH-1:0]                    eng_src_ID,
  output logic [`ADDR_WIDTH-1:0]                  eng_src_addr,
  output logic [`ID_WIDTH-1:0]                    eng_dst_ID,
  output logic [`ADDR_WIDTH-1:0]                  eng_dst_addr,
  output logic [`DMA_SIZE_WIDTH-1:0]              eng_size,
  output logic                                    eng_start,
`ifdef DMA_ARB_TIMEOUT_EN
  output logic                                    timeout_err,
`endif
  input  logic                                    eng_done
);

  localparam int IW = `ID_WIDTH;
  localparam int AW = `ADDR_WIDTH;
  localparam int SW = `DMA_SIZE_WIDTH;
  localparam int PW = $clog2(NUM_MASTERS);

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, BUSY, DONE} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic [PW-1:0] winner_reg, winner_next;
  logic [PW-1:0] winner_inc;
  logic [PW-1:0] rr_winner;
  logic          rr_found;
  logic [PW:0]   idx_sum;
  logic          latch_cmd;

  logic [IW-1:0] eng_src_id_reg, eng_dst_id_reg;
  logic [AW-1:0] eng_src_addr_reg, eng_dst_addr_reg;
  logic [SW-1:0] eng_size_reg;

  // Unpack the flattened command buses so the winner can index them directly.
  logic [IW-1:0] src_id_arr   [NUM_MASTERS];
  logic [AW-1:0] src_addr_arr [NUM_MASTERS];
  logic [IW-1:0] dst_id_arr   [NUM_MASTERS];
  logic [AW-1:0] dst_addr_arr [NUM_MASTERS];
  logic [SW-1:0] size_arr     [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign src_id_arr[gi]   = m_src_ID[gi*IW +: IW];
      assign src_addr_arr[gi] = m_src_addr[gi*AW +: AW];
      assign dst_id_arr[gi]   = m_dst_ID[gi*IW +: IW];
      assign dst_addr_arr[gi] = m_dst_addr[gi*AW +: AW];
      assign size_arr[gi]     = m_size[gi*SW +: SW];
      // permit and done are decoded from registered state, so reset clears them at once.
      assign permit[gi] = (state_reg == GRANT) && (winner_reg == PW'(gi));
      assign done[gi]   = (state_reg == DONE)  && (winner_reg == PW'(gi));
    end
  endgenerate

  // Round-robin search. Offsets are scanned from the far end down, so the
  // last hit is the lowest index at or above ptr, wrapping past NUM_MASTERS-1.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    idx_sum   = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx_sum = {1'b0, ptr_reg} + (PW+1)'(k);
      if (idx_sum >= (PW+1)'(NUM_MASTERS))
        idx_sum = idx_sum - (PW+1)'(NUM_MASTERS);
      if (req[idx_sum[PW-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = idx_sum[PW-1:0];
      end
    end
  end

  assign winner_inc = (winner_reg == PW'(NUM_MASTERS - 1)) ? '0 : winner_reg + 1'b1;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] grant_cnt_reg;
  logic          timeout_err_reg;
  logic          set_timeout;
  assign timeout_err = timeout_err_reg;
`endif

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    winner_next = winner_reg;
    latch_cmd   = 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
    set_timeout = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (rr_found) begin
          winner_next = rr_winner;
          state_next  = GRANT;
        end
      end
      GRANT: begin
        if (m_start[winner_reg]) begin
          latch_cmd  = 1'b1;
          state_next = ISSUE;
        end else if (!req[winner_reg]) begin
          ptr_next   = winner_inc;
          state_next = IDLE;
`ifdef DMA_ARB_TIMEOUT_EN
        end else if (grant_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
          // This is the last permitted GRANT cycle, so the grant is revoked here.
          set_timeout = 1'b1;
          ptr_next    = winner_inc;
          state_next  = IDLE;
`endif
        end
      end
      ISSUE: state_next = BUSY;
      BUSY: begin
        if (eng_done) begin
          ptr_next   = winner_inc;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      ptr_reg          <= '0;
      winner_reg       <= '0;
      eng_src_id_reg   <= '0;
      eng_src_addr_reg <= '0;
      eng_dst_id_reg   <= '0;
      eng_dst_addr_reg <= '0;
      eng_size_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      winner_reg <= winner_next;
      if (latch_cmd) begin
        eng_src_id_reg   <= src_id_arr[winner_reg];
        eng_src_addr_reg <= src_addr_arr[winner_reg];
        eng_dst_id_reg   <= dst_id_arr[winner_reg];
        eng_dst_addr_reg <= dst_addr_arr[winner_reg];
        eng_size_reg     <= size_arr[winner_reg];
      end
    end
  end

`ifdef DMA_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      grant_cnt_reg <= (state_reg == GRANT) ? grant_cnt_reg + 1'b1 : '0;
      if (set_timeout)
        timeout_err_reg <= 1'b1;
    end
  end
`endif

  assign eng_start    = (state_reg == ISSUE);
  assign eng_src_ID   = eng_src_id_reg;
  assign eng_src_addr = eng_src_addr_reg;
  assign eng_dst_ID   = eng_dst_id_reg;
  assign eng_dst_addr = eng_dst_addr_reg;
  assign eng_size     = eng_size_reg;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed testbench for dma_arbiter (NUM_MASTERS=4, TIMEOUT_CYCLES=16).
// Inputs change just after a falling edge. Outputs are checked at the
// following falling edge, half a cycle after the rising edge that updated
// the design.

`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DMA_SIZE_WIDTH
`define DMA_SIZE_WIDTH 16
`endif

module tb_dma_arbiter;
  localparam int N  = 4;
  localparam int IW = `ID_WIDTH;
  localparam int AW = `ADDR_WIDTH;
  localparam int SW = `DMA_SIZE_WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      permit;
  logic [N*IW-1:0]   m_src_ID, m_dst_ID;
  logic [N*AW-1:0]   m_src_addr, m_dst_addr;
  logic [N*SW-1:0]   m_size;
  logic [N-1:0]      m_start;
  logic [N-1:0]      done;
  logic [IW-1:0]     eng_src_ID, eng_dst_ID;
  logic [AW-1:0]     eng_src_addr, eng_dst_addr;
  logic [SW-1:0]     eng_size;
  logic              eng_start;
  logic              eng_done;
`ifdef DMA_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  int tests = 0;
  int fails = 0;

  dma_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .permit       (permit),
    .m_src_ID     (m_src_ID),
    .m_src_addr   (m_src_addr),
    .m_dst_ID     (m_dst_ID),
    .m_dst_addr   (m_dst_addr),
    .m_size       (m_size),
    .m_start      (m_start),
    .done         (done),
    .eng_src_ID   (eng_src_ID),
    .eng_src_addr (eng_src_addr),
    .eng_dst_ID   (eng_dst_ID),
    .eng_dst_addr (eng_dst_addr),
    .eng_size     (eng_size),
    .eng_start    (eng_start),
`ifdef DMA_ARB_TIMEOUT_EN
    .timeout_err  (timeout_err),
`endif
    .eng_done     (eng_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("[TB] check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_cmd(input int i, input logic [IW-1:0] sid, input logic [AW-1:0] saddr,
                         input logic [IW-1:0] did, input logic [AW-1:0] daddr,
                         input logic [SW-1:0] sz);
    m_src_ID[i*IW +: IW]   = sid;
    m_src_addr[i*AW +: AW] = saddr;
    m_dst_ID[i*IW +: IW]   = did;
    m_dst_addr[i*AW +: AW] = daddr;
    m_size[i*SW +: SW]     = sz;
  endtask

  // Entered at the falling edge of a GRANT cycle for master k. Runs the
  // complete transfer and returns at the falling edge of the next GRANT
  // cycle (req stays held).
  task automatic rr_step(input int k);
    logic [SW-1:0] exp_size;
    exp_size = (k == 3) ? '0 : SW'(16 + k);
    check("rr_permit", permit, 64'(1 << k));
    m_start = N'(1 << k);
    @(negedge clk);                       // ISSUE
    check("rr_eng_start", eng_start, 1);
    check("rr_src_addr", eng_src_addr, 64'(32'h1000 + k));
    check("rr_size", eng_size, exp_size);
    m_start = '0;
    @(negedge clk);                       // BUSY
    eng_done = 1'b1;
    @(negedge clk);                       // DONE
    check("rr_done", done, 64'(1 << k));
    eng_done = 1'b0;
    @(negedge clk);                       // IDLE
    @(negedge clk);                       // GRANT of the next winner
  endtask

  initial begin
    rst = 1'b1; req = '0; m_start = '0; eng_done = 1'b0;
    m_src_ID = '0; m_src_addr = '0; m_dst_ID = '0; m_dst_addr = '0; m_size = '0;

    // ---- reset state
    repeat (2) @(negedge clk);
    check("rst_permit", permit, 0);
    check("rst_done", done, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_src_addr", eng_src_addr, 0);
    check("rst_size", eng_size, 0);
`ifdef DMA_ARB_TIMEOUT_EN
    check("rst_timeout", timeout_err, 0);
`endif

    // ---- single master
    rst = 1'b0;
    set_cmd(0, 4'h3, 32'h100, 4'h5, 32'h200, 16'd8);
    req = 4'b0001;
    @(negedge clk);
    check("s_permit", permit, 4'b0001);
    m_start = 4'b0001;
    @(negedge clk);                       // ISSUE
    check("s_eng_start", eng_start, 1);
    check("s_permit_drop", permit, 0);
    check("s_src_addr", eng_src_addr, 32'h100);
    check("s_dst_addr", eng_dst_addr, 32'h200);
    check("s_size", eng_size, 8);
    m_start = '0; req = '0;
    eng_done = 1'b1;                      // seen only in ISSUE, must be ignored
    @(negedge clk);                       // BUSY
    eng_done = 1'b0;
    check("s_start_1cyc", eng_start, 0);
    check("s_no_early_done", done, 0);
    @(negedge clk);                       // still BUSY
    check("s_busy_hold", done, 0);
    check("s_busy_src", eng_src_addr, 32'h100);
    eng_done = 1'b1;
    @(negedge clk);                       // DONE
    check("s_done", done, 4'b0001);
    eng_done = 1'b0;
    @(negedge clk);                       // IDLE
    check("s_done_1cyc", done, 0);

    // ---- round robin with every master requesting from reset
    for (int i = 0; i < N; i++)
      set_cmd(i, IW'(i + 1), 32'h1000 + i, IW'(i + 8), 32'h2000 + i,
              (i == 3) ? SW'(0) : SW'(16 + i));
    rst = 1'b1; req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rr_step(0);
    rr_step(1);
    rr_step(2);
    rr_step(3);
    rr_step(0);

    // ---- stray start while master 1 holds the grant
    check("st_permit", permit, 4'b0010);
    m_start = 4'b0100;
    @(negedge clk);
    check("st_permit_hold", permit, 4'b0010);
    check("st_no_start", eng_start, 0);
    check("st_src_addr", eng_src_addr, 32'h1000);
    check("st_dst_addr", eng_dst_addr, 32'h2000);
    m_start = '0;

    // ---- master 1 withdraws; the next grant goes to master 2, not 0
    req = 4'b0101;
    @(negedge clk);                       // IDLE
    check("wd_permit", permit, 0);
    check("wd_no_start", eng_start, 0);
    check("wd_no_done", done, 0);
    @(negedge clk);
    check("wd_next_grant", permit, 4'b0100);

    // ---- reset while master 2's transfer is in BUSY
    m_start = 4'b0100;
    @(negedge clk);                       // ISSUE
    check("rb_eng_start", eng_start, 1);
    check("rb_src_addr", eng_src_addr, 32'h1002);
    m_start = '0;
    @(negedge clk);                       // BUSY
    eng_done = 1'b1;
    rst = 1'b1;
    #1;
    check("rb_permit", permit, 0);
    check("rb_eng_start0", eng_start, 0);
    check("rb_done", done, 0);
    check("rb_src_clr", eng_src_addr, 0);
    @(negedge clk);
    check("rb_done_hold", done, 0);
    eng_done = 1'b0; req = 4'b1000; rst = 1'b0;
    @(negedge clk);
    check("rb_resume", permit, 4'b1000);

`ifdef DMA_ARB_TIMEOUT_EN
    // ---- grant revoked after 16 cycles without m_start
    repeat (15) @(negedge clk);
    check("to_cycle16", permit, 4'b1000);
    check("to_not_yet", timeout_err, 0);
    @(negedge clk);
    check("to_permit", permit, 0);
    check("to_err", timeout_err, 1);
    req = '0;
    repeat (3) @(negedge clk);
    check("to_sticky", timeout_err, 1);
    check("to_idle", permit, 0);
`else
    // ---- grant is held indefinitely while req stays high
    repeat (20) @(negedge clk);
    check("hold_permit", permit, 4'b1000);
    check("hold_no_start", eng_start, 0);
    req = '0;
    @(negedge clk);
    check("hold_release", permit, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
